// File: rtl/z_rca_mult_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : z_rca_mult_ctrl_pkg
//  Brief    : Shared definitions for the shift-and-add multiplier controller:
//             state encodings, default operand width, counter width helper.
//  Revision : 1.0  initial release
// ============================================================================
package z_rca_mult_ctrl_pkg;

    // Default operand width of the multiplier.
    localparam int C_DEFAULT_N = 4;

    // Controller states. 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Width of an iteration counter able to hold values 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : z_rca_mult_ctrl_pkg
`default_nettype wire

// File: rtl/z_n_rca.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : z_n_rca
//  Brief    : N-bit ripple-carry adder built from a chain of full adders.
//             Purely combinational.
//  Revision : 1.0  initial release
// ============================================================================
module z_n_rca #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);

    // carry[i] is the carry into bit i; carry[N] leaves the adder.
    logic [N:0] carry;

    assign carry[0] = c_in;

    // One full adder per bit, carry rippling from LSB to MSB.
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = carry[N];

endmodule : z_n_rca
`default_nettype wire

// File: rtl/z_rca_mult_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : z_rca_mult_ctrl
//  Brief    : Sequential shift-and-add unsigned multiplier. Sequences one
//             shared z_n_rca over N iterations and presents the 2N-bit
//             product {A,Q} with a one-cycle done strobe.
//  Revision : 1.0  initial release
// ============================================================================
module z_rca_mult_ctrl
    import z_rca_mult_ctrl_pkg::*;
#(
    parameter int N = C_DEFAULT_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int            CW     = cnt_width(N);
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    state_t        state;
    state_t        state_nxt;
    logic          load;
    logic          shift;

    logic [N-1:0]  m;        // multiplicand
    logic [N-1:0]  q;        // multiplier, low half of the product
    logic [N-1:0]  acc;      // accumulator, high half of the product
    logic [CW-1:0] count;    // completed iterations

    logic [N-1:0]  addend;
    logic [N-1:0]  sum;
    logic          c_out;

    // Shared adder: the controller only steers its operands.
    z_n_rca #(
        .N (N)
    ) u_rca (
        .a     (acc),
        .b     (addend),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (c_out)
    );

    // Add the multiplicand only when the current multiplier LSB is set.
    always_comb begin
        addend = '0;
        if (q[0]) begin
            addend = m;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and datapath enables. Start is honoured only in IDLE
    // and DONE; a start seen in DONE reloads without passing through IDLE.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                shift = 1'b1;
                if (count == C_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture and shift-right of {c_out, sum, Q}. The adder carry
    // lands directly in the accumulator MSB, so no separate carry flop is
    // needed to keep it.
    always_ff @(posedge clk) begin
        if (rst) begin
            m     <= '0;
            q     <= '0;
            acc   <= '0;
            count <= '0;
        end else if (load) begin
            m     <= a;
            q     <= b;
            acc   <= '0;
            count <= '0;
        end else if (shift) begin
            acc   <= {c_out, sum[N-1:1]};
            q     <= {sum[0], q[N-1:1]};
            count <= count + CW'(1);
        end
    end

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign product = {acc, q};

endmodule : z_rca_mult_ctrl
`default_nettype wire

// File: tb/tb_z_rca_mult_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_z_rca_mult_ctrl
//  Brief    : Self-checking bench for z_rca_mult_ctrl at N=4 and N=8.
//  Revision : 1.0  initial release
// ============================================================================
module tb_z_rca_mult_ctrl;

    localparam int C_TMO = 40;

    logic        clk = 1'b0;
    logic        rst;

    logic        start4;
    logic [3:0]  a4, b4;
    logic        busy4, done4;
    logic [7:0]  prod4;

    logic        start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] prod8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
        string      name;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    z_rca_mult_ctrl #(.N(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (start4),
        .a       (a4),
        .b       (b4),
        .busy    (busy4),
        .done    (done4),
        .product (prod4)
    );

    z_rca_mult_ctrl #(.N(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .start   (start8),
        .a       (a8),
        .b       (b8),
        .busy    (busy8),
        .done    (done8),
        .product (prod8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait for done on the N=4 instance; cyc counts negedges since launch.
    task automatic wait4(inout int cyc, output bit busy_ok);
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (!busy4) busy_ok = 1'b0;
        end while (!done4 && cyc < C_TMO);
    endtask

    task automatic launch4(input logic [3:0] ta, input logic [3:0] tb_);
        @(negedge clk);
        a4 = ta;
        b4 = tb_;
        start4 = 1'b1;
    endtask

    // Single multiply on N=4: latency, busy, product, then release.
    task automatic run4(input logic [3:0] ta, input logic [3:0] tb_,
                        input logic [7:0] exp, input string name);
        int cyc;
        bit bok;
        logic [7:0] held;
        launch4(ta, tb_);
        @(negedge clk);
        cyc = 1;
        start4 = 1'b0;
        a4 = ~ta;
        b4 = ~tb_;
        wait4(cyc, bok);
        check({name, "_lat"},  32'(cyc), 32'd5);
        check({name, "_busy"}, 32'(bok), 32'd1);
        check({name, "_prod"}, 32'(prod4), 32'(exp));
        held = prod4;
        @(negedge clk);
        check({name, "_done_low"}, 32'(done4), 32'd0);
        check({name, "_idle"},     32'(busy4), 32'd0);
        check({name, "_hold"},     32'(prod4), 32'(held));
    endtask

    // Single multiply on N=8 against the reference a*b and N+1 latency.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input string name);
        int cyc;
        bit bok;
        logic [15:0] exp;
        exp = 16'(ta) * 16'(tb_);
        @(negedge clk);
        a8 = ta;
        b8 = tb_;
        start8 = 1'b1;
        cyc = 0;
        bok = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            start8 = 1'b0;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            if (!busy8) bok = 1'b0;
        end while (!done8 && cyc < C_TMO);
        check({name, "_lat"},  32'(cyc), 32'd9);
        check({name, "_busy"}, 32'(bok), 32'd1);
        check({name, "_prod"}, 32'(prod8), 32'(exp));
    endtask

    initial begin
        int cyc;
        bit bok;

        vecs[0] = '{4'hF, 4'hF, 8'hE1, "ff_ff"};
        vecs[1] = '{4'h8, 4'hF, 8'h78, "8_f"};
        vecs[2] = '{4'h0, 4'hF, 8'h00, "0_f"};
        vecs[3] = '{4'hF, 4'h0, 8'h00, "f_0"};
        vecs[4] = '{4'hD, 4'hB, 8'h8F, "d_b"};

        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        check("rst_prod4", 32'(prod4), 32'd0);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_prod8", 32'(prod8), 32'd0);
        rst = 1'b0;

        // Directed operand table.
        for (int i = 0; i < 5; i++) begin
            run4(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].name);
        end

        // Start held high: back-to-back multiplies, operands changed after
        // the first accept so the DONE edge reloads 7 and 9.
        launch4(4'h3, 4'h5);
        @(negedge clk);
        cyc = 1;
        a4 = 4'h7;
        b4 = 4'h9;
        wait4(cyc, bok);
        check("b2b_lat1",  32'(cyc), 32'd5);
        check("b2b_prod1", 32'(prod4), 32'h0F);
        cyc = 0;
        wait4(cyc, bok);
        start4 = 1'b0;
        check("b2b_lat2",  32'(cyc), 32'd5);
        check("b2b_busy2", 32'(bok), 32'd1);
        check("b2b_prod2", 32'(prod4), 32'h3F);
        @(negedge clk);
        check("b2b_idle", 32'(busy4), 32'd0);

        // Start during RUN must be ignored.
        launch4(4'h9, 4'h6);
        @(negedge clk);
        cyc = 1;
        start4 = 1'b0;
        @(negedge clk);
        cyc++;
        start4 = 1'b1;
        a4 = 4'hF;
        b4 = 4'hF;
        @(negedge clk);
        cyc++;
        start4 = 1'b0;
        wait4(cyc, bok);
        check("midrun_lat",  32'(cyc), 32'd5);
        check("midrun_prod", 32'(prod4), 32'h36);
        @(negedge clk);
        check("midrun_idle", 32'(busy4), 32'd0);

        // Reset on the third RUN cycle discards the partial result.
        launch4(4'hF, 4'hF);
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_busy", 32'(busy4), 32'd0);
        check("mrst_done", 32'(done4), 32'd0);
        check("mrst_prod", 32'(prod4), 32'd0);
        rst = 1'b0;
        run4(4'h6, 4'h7, 8'h2A, "after_rst");

        // Wide instance: corners then random pairs.
        run8(8'hFF, 8'hFF, "w_ff_ff");
        run8(8'h00, 8'hFF, "w_00_ff");
        run8(8'h80, 8'h01, "w_80_01");
        for (int i = 0; i < 200; i++) begin
            run8(8'($urandom), 8'($urandom), $sformatf("w_rnd%0d", i));
        end
        @(negedge clk);
        check("w_idle", 32'(busy8), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_z_rca_mult_ctrl
`default_nettype wire
